// File: rtl/inst_axi_read_bridge_if.sv
// Fetch-side SRAM-like request/response signals and the AXI4 AR/R channels seen by the bridge.
// The slave modport is the bridge's view; master is the fetch stage plus AXI fabric.
interface inst_axi_read_bridge_if;
    logic        req;
    logic [31:0] addr;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;
    logic        bus_err;
    logic        cancel;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata_axi;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport slave (
        input  req, addr, cancel, arready, rid, rdata_axi, rresp, rlast, rvalid,
        output addr_ok, data_ok, rdata, bus_err,
        output arid, araddr, arlen, arsize, arburst, arvalid, rready
    );

    modport master (
        output req, addr, cancel, arready, rid, rdata_axi, rresp, rlast, rvalid,
        input  addr_ok, data_ok, rdata, bus_err,
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready
    );
endinterface

// File: rtl/inst_axi_read_bridge.sv
// Instruction fetch to single-beat AXI4 read bridge: one AR register, in-order R return,
// and a drop counter that discards beats of requests accepted up to a cancel.
module inst_axi_read_bridge #(
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter logic [3:0]  AXI_ID          = 4'h0
) (
    input  logic                    clk,
    input  logic                    resetn,
    inst_axi_read_bridge_if.slave   bus
);
    localparam int unsigned   CW      = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

    typedef enum logic {AR_IDLE, AR_PEND} ar_state_t;

    ar_state_t      ar_state_q, ar_state_d;
    logic [31:0]    araddr_q, araddr_d;
    logic [CW-1:0]  inflight_q, inflight_d;
    logic [CW-1:0]  drop_cnt_q, drop_cnt_d;
    logic           handshake;
    logic           deliver;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ar_state_q <= AR_IDLE;
            araddr_q   <= '0;
            inflight_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            ar_state_q <= ar_state_d;
            araddr_q   <= araddr_d;
            inflight_q <= inflight_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always_comb begin
        ar_state_d = ar_state_q;
        araddr_d   = araddr_q;
        // Registered inflight only: a beat returning this cycle frees a slot next cycle.
        handshake  = bus.req && ((ar_state_q == AR_IDLE) || bus.arready)
                     && (inflight_q < MAX_CNT);
        if (handshake) begin
            ar_state_d = AR_PEND;
            araddr_d   = bus.addr;
        end else if (bus.arready && (ar_state_q == AR_PEND)) begin
            ar_state_d = AR_IDLE;
        end

        inflight_d = inflight_q + CW'(handshake) - CW'(bus.rvalid);
        deliver    = bus.rvalid && (drop_cnt_q == '0) && !bus.cancel;

        // Every request still owed a beat after this cycle, including a same-cycle handshake,
        // becomes stale on cancel; drops are always the oldest beats, so a count suffices.
        drop_cnt_d = drop_cnt_q;
        if (bus.cancel) begin
            drop_cnt_d = inflight_d;
        end else if (bus.rvalid && (drop_cnt_q != '0)) begin
            drop_cnt_d = drop_cnt_q - CW'(1);
        end
    end

    assign bus.addr_ok = handshake;
    assign bus.data_ok = deliver;
    assign bus.rdata   = bus.rdata_axi;
    assign bus.bus_err = bus.rresp[1];
    assign bus.arid    = AXI_ID;
    assign bus.araddr  = araddr_q;
    assign bus.arlen   = '0;
    assign bus.arsize  = 3'b010;
    assign bus.arburst = 2'b01;
    assign bus.arvalid = (ar_state_q == AR_PEND);
    assign bus.rready  = 1'b1;

    logic unused_bits;
    assign unused_bits = ^{bus.rid, bus.rlast, bus.rresp[0]};

    a_no_underflow: assert property (@(posedge clk) disable iff (!resetn)
        !(bus.rvalid && (inflight_q == '0)));
endmodule

// File: doc/inst_axi_read_bridge.md
Name: inst_axi_read_bridge

Overview:
- Responder end of the fetch-side instruction SRAM-like interface (req/addr → addr_ok, data_ok/rdata, cancel).
- Converts fetch requests into single-beat AXI4 reads and returns instruction words in order.
- Drops responses belonging to requests issued before a pipeline flush or branch redirect, signalled by `cancel`.
- Sits between the pre-fetch/fetch stages and the AXI crossbar.

Parameters:
- MAX_OUTSTANDING, 4, maximum in-flight reads, counting the pending AR entry; range 1..15.
- AXI_ID, 4'h0, constant ARID driven on every read.

Ports:
- clk  input  1  clock; all state updates on its rising edge
- resetn  input  1  asynchronous active-low reset
- req  input  1  fetch request valid
- addr  input  32  physical fetch address, word aligned
- addr_ok  output  1  request accepted this cycle (req && addr_ok = handshake)
- data_ok  output  1  rdata valid for the oldest non-cancelled request
- rdata  output  32  instruction word
- bus_err  output  1  data_ok beat carried RRESP SLVERR/DECERR
- cancel  input  1  discard responses of every request accepted up to and including this cycle
- arid  output  4  = AXI_ID
- araddr  output  32  registered address
- arlen  output  8  constant 0
- arsize  output  3  constant 3'b010
- arburst  output  2  constant 2'b01
- arvalid  output  1  AR valid
- arready  input  1  AR ready
- rid  input  4  ignored; responses are in order (single ID)
- rdata_axi  input  32  R data
- rresp  input  2  R response
- rlast  input  1  ignored; single beat
- rvalid  input  1  R valid
- rready  output  1  constant 1

Behaviour:
- Reset (resetn=0, asynchronous):
  - ar_pend=0, araddr=0, inflight=0, drop_cnt=0.
  - All outputs 0 except the constants (arid/arlen/arsize/arburst/rready). rready=1 after reset; it is constant 1.
  - Mid-operation reset abandons all state; the AXI slave is reset by the same resetn.
- AR register (one entry):
  - addr_ok = req && (!ar_pend || arready) && (inflight < MAX_OUTSTANDING). inflight is the registered value only; there is no same-cycle R bypass.
  - On req && addr_ok: ar_pend<=1 and araddr<=addr.
  - Else if arready && ar_pend: ar_pend<=0.
  - arvalid = ar_pend.
  - araddr is stable while arvalid && !arready.
  - Back-to-back issue is allowed: a new handshake in the same cycle as arready reloads the register.
- Counters (width $clog2(MAX_OUTSTANDING+1)):
  - inflight_next = inflight + (req&&addr_ok) - rvalid. rready=1, so rvalid is the handshake.
  - inflight never exceeds MAX_OUTSTANDING.
  - inflight never underflows. An rvalid with inflight=0 is a protocol violation; flag it with an assertion in simulation.
- Response path:
  - deliver = rvalid && (drop_cnt==0) && !cancel.
  - data_ok = deliver. rdata = rdata_axi and bus_err = rresp[1], both combinational, zero latency from R.
  - If rvalid && drop_cnt!=0: beat discarded, drop_cnt decrements.
- Cancel:
  - On cancel: drop_cnt <= inflight_next, and any beat arriving in that cycle is also discarded. All requests accepted at or before the cancel cycle, including a same-cycle handshake, are therefore never delivered.
  - Repeated cancel while drop_cnt>0 reloads drop_cnt the same way; the result is a superset, so it stays correct.
  - Requests accepted after the cancel cycle are delivered normally, in order, after the dropped beats drain.
  - cancel never retracts an AR already accepted into the register; that read is issued and its beat dropped.
- Ordering: strictly in order. data_ok count equals the number of accepted, non-cancelled requests.

Test Plan:
- Single fetch:
  - Stimulus: req, addr=0xBFC0_0000; arready immediate; rvalid 3 cycles later with rdata_axi=0x3C08_BFC0.
  - Required: addr_ok in cycle 0; arvalid cycle 1 with araddr=0xBFC0_0000; data_ok=1 with rdata=0x3C08_BFC0; inflight returns to 0.
- Backpressure:
  - Stimulus: req held every cycle, arready=1, R withheld.
  - Required: exactly 4 handshakes, then addr_ok=0.
  - Follow-up: one rvalid → addr_ok reasserts the next cycle.
- Cancel with 3 in flight:
  - Stimulus: cancel asserted while inflight=3; then one new req at 0x100; then 4 R beats.
  - Required: first 3 beats produce no data_ok; 4th beat gives data_ok with its data.
- Same-cycle cancel:
  - Stimulus: cancel coincides with a request handshake and an rvalid beat; inflight was 2.
  - Required: that beat is dropped; drop_cnt=2 (2+1-1); next 2 beats dropped.
- AR stall:
  - Stimulus: arready=0 for 5 cycles after a handshake; req held with a different addr.
  - Required: araddr stable; addr_ok=0 until the arready cycle, then the second handshake occurs in that same cycle.
- Error and reset:
  - Stimulus: rresp=2'b10 on a delivered beat → bus_err=1 with data_ok.
  - Stimulus: resetn pulsed low mid-transaction → arvalid, data_ok and all counters 0 immediately, without waiting for a clock edge.
